// File: rtl/rank_enc_pkg.sv
// Shared types for the rank-order encoder: controller states and emission direction.
package rank_enc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        EMIT,
        FINISH
    } state_t;

    typedef enum logic {
        DESCENDING,
        ASCENDING
    } dir_t;

endpackage

// File: rtl/rank_level_finder.sv
// Combinational search for the next populated intensity level beyond i_level in
// the scan direction. Used only when RANK_ENC_LEVEL_SKIP_EN is defined.
module rank_level_finder
    import rank_enc_pkg::*;
#(
    parameter int PIXEL_MAX_VALUE = 255,
    parameter int PIXEL_BITS      = $clog2(PIXEL_MAX_VALUE + 1)
) (
    input  logic [PIXEL_MAX_VALUE:0] i_present,
    input  logic [PIXEL_BITS-1:0]    i_level,
    input  dir_t                     i_dir,
    output logic [PIXEL_BITS-1:0]    o_level,
    output logic                     o_found
);

    // Loop order makes the last hit the one nearest to i_level.
    always_comb begin
        o_level = i_level;
        o_found = 1'b0;
        if (i_dir == DESCENDING) begin
            for (int v = 0; v <= PIXEL_MAX_VALUE; v++) begin
                if (i_present[v] && (v < int'(i_level))) begin
                    o_level = PIXEL_BITS'(v);
                    o_found = 1'b1;
                end
            end
        end else begin
            for (int v = PIXEL_MAX_VALUE; v >= 0; v--) begin
                if (i_present[v] && (v > int'(i_level))) begin
                    o_level = PIXEL_BITS'(v);
                    o_found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rank_order_encoder.sv
// Rank-order encoder: captures an image on start and streams pixel indexes by intensity level.
// Define RANK_ENC_LEVEL_SKIP_EN to jump straight over empty levels.
module rank_order_encoder
    import rank_enc_pkg::*;
#(
    parameter int IMAGE_SIZE      = 784,
    parameter int PIXEL_MAX_VALUE = 255,
    parameter int PIXEL_BITS      = $clog2(PIXEL_MAX_VALUE + 1),
    parameter int IDX_BITS        = $clog2(IMAGE_SIZE),
    parameter int CNT_BITS        = $clog2(IMAGE_SIZE + 1)
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [PIXEL_BITS-1:0] image [0:IMAGE_SIZE-1],
    input  logic                  start,
    input  logic                  ascending,
    input  logic [PIXEL_BITS-1:0] threshold,
    input  logic                  abort,
    output logic [IDX_BITS-1:0]   out_idx,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_BITS-1:0]   emit_count
);

    localparam logic [PIXEL_BITS-1:0] LP_MAX      = PIXEL_BITS'(PIXEL_MAX_VALUE);
    localparam logic [IDX_BITS-1:0]   LP_LAST_PID = IDX_BITS'(IMAGE_SIZE - 1);

    state_t                r_state;
    dir_t                  r_dir;
    logic [PIXEL_BITS-1:0] r_pix [0:IMAGE_SIZE-1];
    logic [PIXEL_BITS-1:0] r_level;
    logic [CNT_BITS-1:0]   r_remaining;
    logic [IDX_BITS-1:0]   r_pid;
    logic [IDX_BITS-1:0]   r_out_idx;
    logic                  r_out_valid;
    logic                  r_out_last;
    logic                  r_done;
    logic [CNT_BITS-1:0]   r_emit_count;

    logic [PIXEL_BITS-1:0] w_clamped [0:IMAGE_SIZE-1];
    logic [CNT_BITS-1:0]   w_count;
    logic [PIXEL_BITS-1:0] w_step_level;
    logic [PIXEL_BITS-1:0] w_next_level;
    logic                  w_match;
    logic                  w_pid_last;

    always_comb begin
        w_count = '0;
        for (int i = 0; i < IMAGE_SIZE; i++) begin
            w_clamped[i] = (image[i] > LP_MAX) ? LP_MAX : image[i];
            if (w_clamped[i] >= threshold) begin
                w_count = w_count + CNT_BITS'(1);
            end
        end
    end

    assign w_match      = (r_pix[r_pid] == r_level);
    assign w_pid_last   = (r_pid == LP_LAST_PID);
    // Never underflows/overflows in practice: remaining > 0 guarantees a populated level ahead.
    assign w_step_level = (r_dir == DESCENDING) ? (r_level - PIXEL_BITS'(1))
                                                : (r_level + PIXEL_BITS'(1));

`ifdef RANK_ENC_LEVEL_SKIP_EN
    logic [PIXEL_MAX_VALUE:0] r_present;
    logic [PIXEL_MAX_VALUE:0] w_present;
    logic [PIXEL_BITS-1:0]    w_skip_level;
    logic                     w_found;

    always_comb begin
        w_present = '0;
        for (int i = 0; i < IMAGE_SIZE; i++) begin
            if (w_clamped[i] >= threshold) begin
                w_present[w_clamped[i]] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_present <= '0;
        end else if (r_state == IDLE && start) begin
            r_present <= w_present;
        end
    end

    rank_level_finder #(
        .PIXEL_MAX_VALUE (PIXEL_MAX_VALUE),
        .PIXEL_BITS      (PIXEL_BITS)
    ) u_level_finder (
        .i_present (r_present),
        .i_level   (r_level),
        .i_dir     (r_dir),
        .o_level   (w_skip_level),
        .o_found   (w_found)
    );

    assign w_next_level = w_found ? w_skip_level : w_step_level;
`else
    assign w_next_level = w_step_level;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= IDLE;
            r_dir        <= DESCENDING;
            r_level      <= '0;
            r_remaining  <= '0;
            r_pid        <= '0;
            r_out_idx    <= '0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_done       <= 1'b0;
            r_emit_count <= '0;
            for (int i = 0; i < IMAGE_SIZE; i++) begin
                r_pix[i] <= '0;
            end
        end else if (abort && (r_state != IDLE)) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < IMAGE_SIZE; i++) begin
                            r_pix[i] <= w_clamped[i];
                        end
                        r_dir        <= ascending ? ASCENDING : DESCENDING;
                        r_level      <= ascending ? threshold : LP_MAX;
                        r_emit_count <= w_count;
                        r_remaining  <= w_count;
                        r_pid        <= '0;
                        if (w_count == '0) begin
                            r_state <= FINISH;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (w_match) begin
                        r_out_idx   <= r_pid;
                        r_out_valid <= 1'b1;
                        r_out_last  <= (r_remaining == CNT_BITS'(1));
                        r_state     <= EMIT;
                    end else if (w_pid_last) begin
                        r_pid   <= '0;
                        r_level <= w_next_level;
                    end else begin
                        r_pid <= r_pid + IDX_BITS'(1);
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_remaining <= r_remaining - CNT_BITS'(1);
                        if (r_out_last) begin
                            r_state <= FINISH;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= SCAN;
                            if (w_pid_last) begin
                                r_pid   <= '0;
                                r_level <= w_next_level;
                            end else begin
                                r_pid <= r_pid + IDX_BITS'(1);
                            end
                        end
                    end
                end
                FINISH: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign out_idx    = r_out_idx;
    assign out_valid  = r_out_valid;
    assign out_last   = r_out_last;
    assign done       = r_done;
    assign emit_count = r_emit_count;
    assign busy       = (r_state != IDLE);

endmodule
